// File: rtl/ss_sync_fifo.sv
// ss_sync_fifo: single-clock show-ahead FIFO with ready/enable handshakes.
// Depth is 2**Bw_a entries. The head entry is presented on rd_do
// combinationally, so the consumer samples it in the same cycle it pops.
// Both flags come from the registered occupancy count alone, never
// combinationally from wr_en or rd_en.
module ss_sync_fifo #(
    parameter int Bw_d = 8,
    parameter int Bw_a = 5
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [Bw_d-1:0] wr_di,
    input  logic            wr_en,
    input  logic            rd_en,
    output logic            wr_rdy,
    output logic            rd_rdy,
    output logic [Bw_d-1:0] rd_do
);

    localparam int            DEPTH    = 1 << Bw_a;
    localparam logic [Bw_a:0] FULL_CNT = (Bw_a + 1)'(DEPTH);

    // Storage is deliberately not reset. After a reset, the pointers and the
    // count are cleared, so any stale contents cannot be observed.
    logic [Bw_d-1:0] mem [DEPTH];
    logic [Bw_a-1:0] wr_ptr;
    logic [Bw_a-1:0] rd_ptr;
    logic [Bw_a:0]   count;

    logic do_wr;
    logic do_rd;

    // The flags depend only on the count. A write while full and a read while
    // empty are dropped by qualifying each request with its own flag.
    always_comb begin
        wr_rdy = (count != FULL_CNT);
        rd_rdy = (count != '0);
        do_wr  = wr_en & wr_rdy;
        do_rd  = rd_en & rd_rdy;
    end

    // Show-ahead output. It is forced to zero while empty so that the
    // consumer never sees stale memory contents.
    always_comb begin
        rd_do = '0;
        if (rd_rdy) rd_do = mem[rd_ptr];
    end

    // Memory write port. Only accepted writes update the array.
    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= wr_di;
    end

    // Pointer registers. They wrap naturally modulo the depth.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Occupancy count. When a write and a read happen together, the count
    // is unchanged.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else begin
            case ({do_wr, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_ss_sync_fifo.sv
// Directed bench for ss_sync_fifo. It runs a default 8x32 instance and a
// narrow 3x32 instance. Inputs are driven and outputs sampled on the
// falling clock edge.
module tb_ss_sync_fifo;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] wr_di = '0;
    logic       wr_en = 1'b0;
    logic       rd_en = 1'b0;
    logic       wr_rdy, rd_rdy;
    logic [7:0] rd_do;

    logic [2:0] n_wr_di = '0;
    logic       n_wr_en = 1'b0;
    logic       n_rd_en = 1'b0;
    logic       n_wr_rdy, n_rd_rdy;
    logic [2:0] n_rd_do;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    ss_sync_fifo #(.Bw_d(8), .Bw_a(5)) dut (
        .clk(clk), .reset(reset), .wr_di(wr_di), .wr_en(wr_en), .rd_en(rd_en),
        .wr_rdy(wr_rdy), .rd_rdy(rd_rdy), .rd_do(rd_do)
    );

    ss_sync_fifo #(.Bw_d(3), .Bw_a(5)) dut_n (
        .clk(clk), .reset(reset), .wr_di(n_wr_di), .wr_en(n_wr_en), .rd_en(n_rd_en),
        .wr_rdy(n_wr_rdy), .rd_rdy(n_rd_rdy), .rd_do(n_rd_do)
    );

    // Drive one cycle on the default instance. Inputs are set at the falling
    // edge, the rising edge follows, and control returns at the next falling
    // edge.
    task automatic step(input logic we, input logic [7:0] d, input logic re);
        wr_en = we; wr_di = d; rd_en = re;
        @(negedge clk);
        wr_en = 1'b0; rd_en = 1'b0;
    endtask

    task automatic nstep(input logic we, input logic [2:0] d, input logic re);
        n_wr_en = we; n_wr_di = d; n_rd_en = re;
        @(negedge clk);
        n_wr_en = 1'b0; n_rd_en = 1'b0;
    endtask

    task automatic test_reset;
        // Reset is held from time 0.
        #1;
        total++;
        if ({wr_rdy, rd_rdy, rd_do} !== {1'b1, 1'b0, 8'h00})
            $display("FAIL reset_initial: got wr_rdy=%b rd_rdy=%b rd_do=%h, want 1 0 00",
                     wr_rdy, rd_rdy, rd_do);
        else passed++;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 5; i++) step(1'b1, 8'h11 + 8'(i), 1'b0);
        total++;
        if (rd_do !== 8'h11) $display("FAIL reset_prefill: got %h, want 11", rd_do);
        else passed++;
        // Assert reset between clock edges. The flags must clear at once.
        #2 reset = 1'b1;
        #1;
        total++;
        if ({wr_rdy, rd_rdy, rd_do} !== {1'b1, 1'b0, 8'h00})
            $display("FAIL reset_async: got wr_rdy=%b rd_rdy=%b rd_do=%h, want 1 0 00",
                     wr_rdy, rd_rdy, rd_do);
        else passed++;
        @(negedge clk);
        reset = 1'b0;
        step(1'b1, 8'h3C, 1'b0);
        total++;
        if ({rd_rdy, rd_do} !== {1'b1, 8'h3C})
            $display("FAIL reset_fresh: got rd_rdy=%b rd_do=%h, want 1 3c", rd_rdy, rd_do);
        else passed++;
        step(1'b0, 8'h00, 1'b1);
        total++;
        if (rd_rdy !== 1'b0) $display("FAIL reset_drain: got rd_rdy=%b, want 0", rd_rdy);
        else passed++;
    endtask

    task automatic test_order;
        logic [7:0] exp_d [3];
        exp_d[0] = 8'h01; exp_d[1] = 8'h80; exp_d[2] = 8'hA5;
        step(1'b1, 8'h01, 1'b0);
        total++;
        if ({rd_rdy, rd_do} !== {1'b1, 8'h01})
            $display("FAIL order_showahead: got rd_rdy=%b rd_do=%h, want 1 01", rd_rdy, rd_do);
        else passed++;
        step(1'b1, 8'h80, 1'b0);
        step(1'b1, 8'hA5, 1'b0);
        for (int i = 0; i < 3; i++) begin
            total++;
            if (rd_do !== exp_d[i])
                $display("FAIL order_pop%0d: got %h, want %h", i, rd_do, exp_d[i]);
            else passed++;
            step(1'b0, 8'h00, 1'b1);
        end
        total++;
        if ({rd_rdy, rd_do} !== {1'b0, 8'h00})
            $display("FAIL order_empty: got rd_rdy=%b rd_do=%h, want 0 00", rd_rdy, rd_do);
        else passed++;
    endtask

    task automatic test_full;
        for (int i = 0; i < 32; i++) begin
            if (i == 31) begin
                total++;
                if (wr_rdy !== 1'b1) $display("FAIL full_before32: got wr_rdy=%b, want 1", wr_rdy);
                else passed++;
            end
            step(1'b1, 8'(i), 1'b0);
        end
        total++;
        if (wr_rdy !== 1'b0) $display("FAIL full_flag: got wr_rdy=%b, want 0", wr_rdy);
        else passed++;
        step(1'b1, 8'hFF, 1'b0);
        total++;
        if ({wr_rdy, rd_do} !== {1'b0, 8'h00})
            $display("FAIL full_drop: got wr_rdy=%b head=%h, want 0 00", wr_rdy, rd_do);
        else passed++;
        for (int i = 0; i < 32; i++) begin
            total++;
            if (rd_do !== 8'(i)) $display("FAIL full_pop%0d: got %h, want %h", i, rd_do, 8'(i));
            else passed++;
            step(1'b0, 8'h00, 1'b1);
            if (i == 0) begin
                total++;
                if (wr_rdy !== 1'b1) $display("FAIL full_reopen: got wr_rdy=%b, want 1", wr_rdy);
                else passed++;
            end
        end
        total++;
        if ({rd_rdy, wr_rdy} !== 2'b01)
            $display("FAIL full_empty: got rd_rdy=%b wr_rdy=%b, want 0 1", rd_rdy, wr_rdy);
        else passed++;
    endtask

    task automatic test_wrap;
        logic [7:0] wd = 8'h00;
        logic [7:0] rdx = 8'h00;
        int bad = 0;
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 20; i++) begin
                step(1'b1, wd, 1'b0);
                wd++;
                if (wr_rdy !== 1'b1 || rd_rdy !== 1'b1) bad++;
            end
            for (int i = 0; i < 20; i++) begin
                total++;
                if (rd_do !== rdx) $display("FAIL wrap_r%0d_i%0d: got %h, want %h", r, i, rd_do, rdx);
                else passed++;
                step(1'b0, 8'h00, 1'b1);
                rdx++;
                if (i < 19 && rd_rdy !== 1'b1) bad++;
            end
            total++;
            if (rd_rdy !== 1'b0) $display("FAIL wrap_empty_r%0d: got rd_rdy=%b, want 0", r, rd_rdy);
            else passed++;
        end
        total++;
        if (bad !== 0) $display("FAIL wrap_flags: got %0d spurious flag samples, want 0", bad);
        else passed++;
    endtask

    task automatic test_simultaneous;
        // Empty FIFO with both requests: only the write takes effect.
        step(1'b1, 8'h42, 1'b1);
        total++;
        if ({rd_rdy, rd_do} !== {1'b1, 8'h42})
            $display("FAIL sim_empty: got rd_rdy=%b rd_do=%h, want 1 42", rd_rdy, rd_do);
        else passed++;
        step(1'b0, 8'h00, 1'b1);
        // Full FIFO with both requests: only the read takes effect.
        for (int i = 0; i < 32; i++) step(1'b1, 8'h40 + 8'(i), 1'b0);
        step(1'b1, 8'hEE, 1'b1);
        total++;
        if ({wr_rdy, rd_do} !== {1'b1, 8'h41})
            $display("FAIL sim_full: got wr_rdy=%b rd_do=%h, want 1 41", wr_rdy, rd_do);
        else passed++;
        for (int i = 1; i < 32; i++) begin
            total++;
            if (rd_do !== 8'h40 + 8'(i))
                $display("FAIL sim_full_pop%0d: got %h, want %h", i, rd_do, 8'h40 + 8'(i));
            else passed++;
            step(1'b0, 8'h00, 1'b1);
        end
        total++;
        if (rd_rdy !== 1'b0) $display("FAIL sim_full_nostore: got rd_rdy=%b, want 0", rd_rdy);
        else passed++;
        // Half-full FIFO with both requests: the count stays at 10.
        for (int i = 0; i < 10; i++) step(1'b1, 8'h60 + 8'(i), 1'b0);
        for (int k = 0; k < 8; k++) begin
            total++;
            if (rd_do !== 8'h60 + 8'(k))
                $display("FAIL sim_half_k%0d: got %h, want %h", k, rd_do, 8'h60 + 8'(k));
            else passed++;
            step(1'b1, 8'h6A + 8'(k), 1'b1);
        end
        for (int i = 0; i < 10; i++) begin
            total++;
            if (rd_rdy !== 1'b1 || rd_do !== 8'h68 + 8'(i))
                $display("FAIL sim_half_drain%0d: got rdy=%b %h, want 1 %h",
                         i, rd_rdy, rd_do, 8'h68 + 8'(i));
            else passed++;
            step(1'b0, 8'h00, 1'b1);
        end
        total++;
        if (rd_rdy !== 1'b0) $display("FAIL sim_half_count: got rd_rdy=%b, want 0", rd_rdy);
        else passed++;
    endtask

    task automatic test_narrow;
        total++;
        if ({n_rd_rdy, n_rd_do} !== {1'b0, 3'd0})
            $display("FAIL narrow_idle: got rdy=%b do=%0d, want 0 0", n_rd_rdy, n_rd_do);
        else passed++;
        for (int c = 7; c >= 0; c--) nstep(1'b1, 3'(c), 1'b0);
        for (int c = 7; c >= 0; c--) begin
            total++;
            if (n_rd_do !== 3'(c)) $display("FAIL narrow_code%0d: got %0d, want %0d", c, n_rd_do, c);
            else passed++;
            nstep(1'b0, 3'd0, 1'b1);
        end
        total++;
        if ({n_rd_rdy, n_rd_do} !== {1'b0, 3'd0})
            $display("FAIL narrow_empty: got rdy=%b do=%0d, want 0 0", n_rd_rdy, n_rd_do);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_order();
        test_full();
        test_wrap();
        test_simultaneous();
        test_narrow();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/ss_sync_fifo.md
# ss_sync_fifo

Single-clock, first-word-fall-through (show-ahead) FIFO with ready/enable handshakes on both sides. Parameterised data width and depth (2^Bw_a entries). Used as the elastic buffer between producers and consumers in the converter datapath, e.g. 8-bit activation values (Bw_d=8, Bw_a=5) and 3-bit bit-place codes (Bw_d=3, Bw_a=5). The module name is `ss_sync_fifo`.

## Interface

Parameters:
- Bw_d, default 8: data width in bits, must be ≥1.
- Bw_a, default 5: address width in bits, must be ≥1. Depth = 2^Bw_a entries (32 by default).

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- wr_di  input  Bw_d  write data.
- wr_en  input  1  write request.
- rd_en  input  1  read (pop) request.
- wr_rdy  output  1  high when not full; a write is accepted only while high.
- rd_rdy  output  1  high when not empty; rd_do is valid while high.
- rd_do  output  Bw_d  head-of-queue data (show-ahead).

## Operation

- Storage: 2^Bw_a × Bw_d memory, write pointer, read pointer, and an occupancy count (Bw_a+1 bits), or equivalently pointers with an extra wrap bit.
- Write: on a rising edge with wr_en=1 and wr_rdy=1, wr_di is stored at the write pointer and the write pointer increments.
- Write when full: wr_en with wr_rdy=0 is ignored; no state changes and the data is dropped.
- Read: on a rising edge with rd_en=1 and rd_rdy=1, the head entry is popped and the read pointer increments.
- Read when empty: rd_en with rd_rdy=0 is ignored.
- Show-ahead: rd_do = memory[read pointer] combinationally while rd_rdy=1. The consumer samples rd_do in the same cycle it asserts rd_en.
- rd_do is forced to 0 whenever rd_rdy=0.
- Pointers wrap modulo 2^Bw_a, with no gap or loss at the wrap.
- Simultaneous wr_en and rd_en:
  - Neither full nor empty: both happen; count is unchanged.
  - Full: only the read happens, because wr_rdy was 0 at the edge. Count decreases by 1.
  - Empty: only the write happens, because rd_rdy was 0 at the edge. Count increases by 1.
- Flags are derived from the registered count only: wr_rdy = (count != 2^Bw_a) and rd_rdy = (count != 0). They never depend combinationally on wr_en or rd_en.
- Reset (asynchronous, any time, including mid-operation):
  - Count and both pointers clear immediately.
  - wr_rdy=1, rd_rdy=0, rd_do=0.
  - Memory contents are not cleared and are unobservable after reset.

## Timing

- Write-to-read latency is 1 cycle. After a write accepted at edge N into an empty FIFO, rd_rdy=1 and rd_do=wr_di are visible after edge N.
- A pop at edge N presents the next entry on rd_do after edge N. Back-to-back pops at 1 entry per cycle are supported.
- Sustained throughput is 1 write and 1 read per cycle.
- wr_rdy falls after the edge that stores the 2^Bw_a-th entry. It rises after the first subsequent pop.
- Reset is asynchronous on assertion: outputs take their reset values without waiting for clk. Deassertion should be synchronised to clk by the instantiating context.

## Test plan

- Reset: assert reset mid-stream with 5 entries held. Required: immediately wr_rdy=1, rd_rdy=0, rd_do=0. After release, a write of 0x3C reads back 0x3C, not stale data.
- Ordering and show-ahead (Bw_d=8, Bw_a=5): write 0x01, 0x80, 0xA5 on consecutive cycles. Required: rd_rdy=1 one cycle after the first write, rd_do=0x01 before any rd_en. Three pops return 0x01, 0x80, 0xA5, then rd_rdy=0.
- Full boundary: write 32 entries (0x00..0x1F). Required: wr_rdy=0 after the 32nd. A 33rd write of 0xFF is dropped. Then 32 pops return 0x00..0x1F in order, and the FIFO ends empty.
- Wrap-around: repeat the pattern "write 20 entries, read 20 entries" 3 times with incrementing data. Required: every read matches the write order across the pointer wrap, and no spurious flag changes occur.
- Simultaneous events:
  - Empty with wr_en=rd_en=1: stores 1 entry.
  - Full with wr_en=rd_en=1: count goes to 31 and the write data is not stored.
  - Half-full (10 entries) with both asserted for 8 cycles: count stays 10 and data order is preserved.
- Narrow configuration (Bw_d=3, Bw_a=5): stream codes 7,6,5,...,0. Required: the codes read back identically, with rd_do 3 bits wide and 0 when empty.
